// File: rtl/wallace_mul_pipe.sv
// ---------------------------------------------------------------------------
// wallace_multiplier
//   Combinational unsigned WIDTH x WIDTH -> PWIDTH multiplier. The partial
//   products are reduced by rows of 3:2 carry-save adders until only two rows
//   are left. A final carry-propagate adder then sums those two rows.
//   Ports:
//     a, b  : WIDTH-bit unsigned operands
//     p     : PWIDTH-bit unsigned product
// ---------------------------------------------------------------------------
module wallace_multiplier #(
   parameter int WIDTH  = 64,
   parameter int PWIDTH = 2 * WIDTH
) (
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic [PWIDTH-1:0] p
);

   // Returns the number of rows present after 'lvl' reduction levels.
   // Each group of three rows becomes two rows. Leftover rows pass through.
   function automatic int rows_after(input int lvl);
      int n;
      n = WIDTH;
      for (int i = 0; i < lvl; i++) n = (n / 3) * 2 + n % 3;
      return n;
   endfunction

   function automatic int num_levels();
      int n;
      int l;
      n = WIDTH;
      l = 0;
      while (n > 2) begin
         n = (n / 3) * 2 + n % 3;
         l++;
      end
      return l;
   endfunction

   localparam int LEVELS = num_levels();

   logic [PWIDTH-1:0] pp [0:WIDTH-1];

   genvar gi, gl;

   for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign pp[gi] = b[gi] ? (PWIDTH'(a) << gi) : '0;
   end

   for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
      localparam int N  = rows_after(gl);
      localparam int G  = N / 3;
      localparam int R  = N % 3;
      localparam int NN = 2 * G + R;

      logic [PWIDTH-1:0] cur [0:N-1];
      logic [PWIDTH-1:0] nxt [0:NN-1];

      if (gl == 0) begin : g_first
         assign cur = pp;
      end else begin : g_rest
         assign cur = g_lvl[gl-1].nxt;
      end

      for (gi = 0; gi < G + R; gi++) begin : g_row
         if (gi < G) begin : g_csa
            // The sum stays in place. The majority carry moves up one bit.
            // A carry out of the top bit is dropped, because the result is
            // only kept modulo 2^PWIDTH.
            assign nxt[2*gi]   = cur[3*gi] ^ cur[3*gi+1] ^ cur[3*gi+2];
            assign nxt[2*gi+1] = ((cur[3*gi] & cur[3*gi+1]) |
                                  (cur[3*gi] & cur[3*gi+2]) |
                                  (cur[3*gi+1] & cur[3*gi+2])) << 1;
         end else begin : g_pass
            assign nxt[G+gi] = cur[2*G+gi];
         end
      end
   end

   assign p = g_lvl[LEVELS-1].nxt[0] + g_lvl[LEVELS-1].nxt[1];

endmodule

// ---------------------------------------------------------------------------
// wallace_mul_pipe
//   Three-stage valid/ready pipeline around wallace_multiplier.
//     S1: operand magnitudes and the result sign
//     S2: registered unsigned product
//     S3: sign-corrected product, which drives the output
//   All stages advance together when S3 is empty or is being consumed.
//   Ports:
//     clk, reset            : clock, asynchronous active-high reset
//     in_valid / in_ready   : operand handshake (in_signed, in_a, in_b)
//     out_valid / out_ready : result handshake (out_product)
//     in_flight             : number of valid stages (0-3)
// ---------------------------------------------------------------------------
module wallace_mul_pipe #(
   parameter int WIDTH  = 64,
   parameter int PWIDTH = 2 * WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_signed,
   input  logic [WIDTH-1:0]  in_a,
   input  logic [WIDTH-1:0]  in_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PWIDTH-1:0] out_product,
   output logic [1:0]        in_flight
);

   logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic              neg1_q, neg1_d, neg2_q, neg2_d;
   logic [WIDTH-1:0]  a_mag_q, a_mag_d, b_mag_q, b_mag_d;
   logic [PWIDTH-1:0] prod_u_q, prod_u_d, out_product_q, out_product_d;
   logic [PWIDTH-1:0] prod_u;
   logic              adv;

   wallace_multiplier #(.WIDTH(WIDTH), .PWIDTH(PWIDTH)) u_mul (
      .a (a_mag_q),
      .b (b_mag_q),
      .p (prod_u)
   );

   // The whole pipe moves as one unit. Bubbles are kept, not squeezed out.
   assign adv = !v3_q || out_ready;

   always_comb begin
      v1_d          = v1_q;
      v2_d          = v2_q;
      v3_d          = v3_q;
      neg1_d        = neg1_q;
      neg2_d        = neg2_q;
      a_mag_d       = a_mag_q;
      b_mag_d       = b_mag_q;
      prod_u_d      = prod_u_q;
      out_product_d = out_product_q;
      if (adv) begin
         v1_d    = in_valid;
         neg1_d  = in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
         // The most negative value negates to itself. As an unsigned number,
         // that bit pattern is the correct magnitude.
         a_mag_d = (in_signed & in_a[WIDTH-1]) ? -in_a : in_a;
         b_mag_d = (in_signed & in_b[WIDTH-1]) ? -in_b : in_b;
         v2_d          = v1_q;
         prod_u_d      = prod_u;
         neg2_d        = neg1_q;
         v3_d          = v2_q;
         // Negating zero gives zero, so a negative zero cannot appear.
         out_product_d = neg2_q ? -prod_u_q : prod_u_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q          <= 1'b0;
         v2_q          <= 1'b0;
         v3_q          <= 1'b0;
         neg1_q        <= 1'b0;
         neg2_q        <= 1'b0;
         a_mag_q       <= '0;
         b_mag_q       <= '0;
         prod_u_q      <= '0;
         out_product_q <= '0;
      end else begin
         v1_q          <= v1_d;
         v2_q          <= v2_d;
         v3_q          <= v3_d;
         neg1_q        <= neg1_d;
         neg2_q        <= neg2_d;
         a_mag_q       <= a_mag_d;
         b_mag_q       <= b_mag_d;
         prod_u_q      <= prod_u_d;
         out_product_q <= out_product_d;
      end
   end

   assign in_ready    = adv;
   assign out_valid   = v3_q;
   assign out_product = out_product_q;
   assign in_flight   = {1'b0, v1_q} + {1'b0, v2_q} + {1'b0, v3_q};

endmodule

// File: tb/tb_wallace_mul_pipe.sv
`timescale 1ns/1ps
module tb_wallace_mul_pipe;
   localparam int W      = 64;
   localparam int P      = 128;
   localparam int NRAND  = 10000;
   localparam int NVEC   = 7;

   logic         clk;
   logic         reset;
   logic         in_valid, in_ready, in_signed;
   logic [W-1:0] in_a, in_b;
   logic         out_valid, out_ready;
   logic [P-1:0] out_product;
   logic [1:0]   in_flight;

   int total;
   int bad;

   typedef struct {
      logic         s;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [P-1:0] exp;
   } vec_t;

   typedef struct {
      logic [P-1:0] exp;
      int           acc;
   } pend_t;

   pend_t sb[$];

   wallace_mul_pipe #(.WIDTH(W), .PWIDTH(P)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_signed   (in_signed),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_product (out_product),
      .in_flight   (in_flight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running after time limit, required to finish");
      $fatal(1, "watchdog");
   end

   // Reference: extend both operands to the product width, then multiply
   // modulo 2^P. Signed values are sign-extended; unsigned values are
   // zero-extended.
   function automatic logic [P-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [P-1:0] ax, bx;
      ax = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      bx = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      return ax * bx;
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0: v = '0;
         1: v = '1;
         2: v = {1'b1, {(W-1){1'b0}}};
         3: v = W'($urandom_range(0, 15));
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   task automatic check(input string name, input logic [P-1:0] act,
                        input logic [P-1:0] exp, input bit quiet = 1'b0);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else if (!quiet) begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t         vt [NVEC];
      logic         bp_s [4];
      logic [W-1:0] bp_a [4];
      logic [W-1:0] bp_b [4];
      logic [P-1:0] bp_e [4];
      int           cyc, sent, iter;
      bit           have, stall_prev;
      logic         cs;
      logic [W-1:0] ca, cb;
      logic [P-1:0] held;
      pend_t        pe;

      total = 0;
      bad   = 0;

      vt[0] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
      vt[1] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                128'h4000_0000_0000_0000_0000_0000_0000_0000};
      vt[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFB};
      vt[3] = '{1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 128'd0};
      vt[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5,
                128'h4_FFFF_FFFF_FFFF_FFFB};
      vt[5] = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                128'hC000_0000_0000_0000_8000_0000_0000_0000};
      vt[6] = '{1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFC,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF4};

      // Reset and idle
      reset = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0;
      out_ready = 1'b1;
      step(); step();
      check("rst_out_valid", P'(out_valid), P'(0));
      check("rst_out_product", out_product, P'(0));
      check("rst_in_ready", P'(in_ready), P'(1));
      check("rst_in_flight", P'(in_flight), P'(0));
      reset = 1'b0;
      step();

      // Directed table with out_ready held high
      for (int i = 0; i < NVEC; i++) begin
         in_valid = 1'b1; in_signed = vt[i].s; in_a = vt[i].a; in_b = vt[i].b;
         step();
         in_valid = 1'b0;
         step();
         check($sformatf("vec%0d_not_early", i), P'(out_valid), P'(0));
         step();
         check($sformatf("vec%0d_valid", i), P'(out_valid), P'(1));
         check($sformatf("vec%0d_product", i), out_product, vt[i].exp);
      end
      step();

      // Back-to-back: 3*5 then 7*0
      in_valid = 1'b1; in_signed = 1'b0; in_a = 64'd3; in_b = 64'd5;
      step();
      in_a = 64'd7; in_b = 64'd0;
      step();
      in_valid = 1'b0;
      step();
      check("b2b_first_valid", P'(out_valid), P'(1));
      check("b2b_first", out_product, P'(15));
      step();
      check("b2b_second_valid", P'(out_valid), P'(1));
      check("b2b_second", out_product, P'(0));
      step();
      check("b2b_drained", P'(out_valid), P'(0));

      // Backpressure: four ops with out_ready low
      bp_s[0] = 1'b0; bp_a[0] = 64'd11;                   bp_b[0] = 64'd13;
      bp_s[1] = 1'b1; bp_a[1] = 64'hFFFF_FFFF_FFFF_FFFE;  bp_b[1] = 64'd9;
      bp_s[2] = 1'b0; bp_a[2] = 64'h1234_5678_9ABC_DEF0;  bp_b[2] = 64'hFEDC_BA98_7654_3210;
      bp_s[3] = 1'b1; bp_a[3] = 64'h8000_0000_0000_0001;  bp_b[3] = 64'hFFFF_FFFF_0000_0000;
      for (int i = 0; i < 4; i++) bp_e[i] = ref_mul(bp_s[i], bp_a[i], bp_b[i]);
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_signed = bp_s[i]; in_a = bp_a[i]; in_b = bp_b[i];
         if (i < 3) step();
      end
      check("bp_in_flight_full", P'(in_flight), P'(3));
      check("bp_in_ready_low", P'(in_ready), P'(0));
      check("bp_out_valid", P'(out_valid), P'(1));
      check("bp_head", out_product, bp_e[0]);
      step(); step();
      check("bp_hold_flight", P'(in_flight), P'(3));
      check("bp_hold_head", out_product, bp_e[0]);
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_comb", P'(in_ready), P'(1));
      step();
      in_valid = 1'b0;
      check("bp_swap_flight", P'(in_flight), P'(3));
      check("bp_out1", out_product, bp_e[1]);
      step();
      check("bp_out2", out_product, bp_e[2]);
      step();
      check("bp_out3_valid", P'(out_valid), P'(1));
      check("bp_out3", out_product, bp_e[3]);
      step();
      check("bp_empty", P'(out_valid), P'(0));
      check("bp_empty_flight", P'(in_flight), P'(0));

      // Reset while three ops are stalled in the pipe
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_signed = 1'b0; in_a = W'(i + 4); in_b = W'(i + 9);
         step();
      end
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("mid_rst_out_valid", P'(out_valid), P'(0));
      check("mid_rst_in_flight", P'(in_flight), P'(0));
      check("mid_rst_in_ready", P'(in_ready), P'(1));
      check("mid_rst_product", out_product, P'(0));
      step(); step();
      #2 reset = 1'b0;
      step();
      out_ready = 1'b1;
      in_valid = 1'b1; in_signed = 1'b0; in_a = 64'd2; in_b = 64'd3;
      step();
      in_valid = 1'b0;
      check("post_rst_no_stale1", P'(out_valid), P'(0));
      step();
      check("post_rst_no_stale2", P'(out_valid), P'(0));
      step();
      check("post_rst_valid", P'(out_valid), P'(1));
      check("post_rst_product", out_product, P'(6));
      step();
      check("post_rst_drained", P'(out_valid), P'(0));

      // Random regression against the reference model
      cyc = 0; sent = 0; iter = 0; have = 1'b0; stall_prev = 1'b0;
      cs = 1'b0; ca = '0; cb = '0; held = '0;
      while ((sent < NRAND || sb.size() > 0) && iter < 60000) begin
         if (!have && sent < NRAND && $urandom_range(0, 3) != 0) begin
            have = 1'b1;
            cs   = 1'($urandom_range(0, 1));
            ca   = rand_op();
            cb   = rand_op();
         end
         in_valid  = have;
         in_signed = cs;
         in_a      = ca;
         in_b      = cb;
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (stall_prev) begin
            check("rand_stall_valid", P'(out_valid), P'(1), 1'b1);
            check("rand_stall_product", out_product, held, 1'b1);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rand_unexpected: got result %h, required no output", out_product);
            end else begin
               pe = sb.pop_front();
               check($sformatf("rand_product cyc=%0d", cyc), out_product, pe.exp);
               check("rand_latency_ge3", P'(cyc - pe.acc >= 3), P'(1), 1'b1);
            end
         end
         stall_prev = out_valid && !out_ready;
         held       = out_product;
         if (in_valid && in_ready) begin
            sb.push_back('{ref_mul(cs, ca, cb), cyc});
            have = 1'b0;
            sent++;
         end
         step();
         cyc++;
         iter++;
      end
      check("rand_all_sent", P'(sent), P'(NRAND));
      check("rand_all_drained", P'(sb.size()), P'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wallace_mul_pipe.md
Name: wallace_mul_pipe

Overview:
- Pipelined, handshaked front/back-end around the combinational 64x64 unsigned wallace_multiplier; instantiates it internally.
- Upstream stage: captures operands and converts signed operands to sign-magnitude.
- Downstream stage: registers the 128-bit unsigned product and re-applies the sign.
- Presents a valid/ready stream interface to the datapath, so the long Wallace/RCA combinational path is bounded by registers on both sides.

Parameters:
- WIDTH, 64, operand width; fixed by wallace_multiplier, and any other value is illegal.
- PWIDTH, 128, product width (2*WIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- in_signed  input  1  1 = treat a/b as two's complement; 0 = unsigned.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_product  output  PWIDTH  full-width product (two's complement if the op was signed).
- in_flight  output  2  number of ops held in stages S1..S3 (0-3).

Behaviour:
- Three register stages, each with its own valid bit: v1, v2, v3.
  - S1: a_mag, b_mag, neg.
  - S2: prod_u (registered wallace_multiplier output of a_mag, b_mag), neg.
  - S3: out_product, out_valid = v3.
- Advance enable: adv = !v3 || out_ready.
  - in_ready = adv. This is a combinational path from out_ready, and it is permitted.
- When adv = 1, all stages shift together on the clock edge:
  - S1 <= input; v1 <= in_valid.
  - S2 <= S1.
  - S3 <= S2.
- When adv = 0, all stages hold. Bubbles are not compressed.
- Accept occurs when in_valid && in_ready. Latency from accept to out_valid is exactly 3 cycles when out_ready is held high.
- Throughput: 1 op per cycle while out_ready = 1.
- S1 conversion:
  - neg = in_signed & (a[63] ^ b[63]).
  - a_mag = (in_signed & a[63]) ? -a : a, as a 64-bit unsigned. Same rule for b_mag.
  - -2^63 has magnitude 2^63, which fits unsigned 64-bit; no special case is needed.
- S3: out_product = neg ? (~prod_u + 1) : prod_u, computed mod 2^128.
  - A zero product with neg = 1 yields 0, not negative zero.
- out_product and all data registers update only when adv = 1. Data in invalid stages is don't-care, but must not be X at the outputs after reset.
- out_product and out_valid are stable while out_valid && !out_ready.
- in_flight = v1 + v2 + v3, registered-consistent (it reflects current stage valids).
- Reset (asynchronous, any cycle, including mid-stall):
  - v1 = v2 = v3 = 0; out_valid = 0; out_product = 0; in_flight = 0; all data registers = 0.
  - in_ready = 1 during and after reset.
  - In-flight ops are discarded; no output handshake completes on the reset edge.
- Simultaneous out_ready && new in_valid while full: the S3 result is consumed and the new op is accepted in the same cycle.
- in_valid with in_ready = 0: the op is not captured; the producer must hold it.

Test Plan:
- Reset then idle:
  - reset=1 async mid-cycle -> out_valid=0, out_product=0, in_ready=1, in_flight=0 immediately.
- Unsigned basic, out_ready=1:
  - a=0xFFFF_FFFF_FFFF_FFFF, b=0xFFFF_FFFF_FFFF_FFFF, in_signed=0 -> 3 cycles later out_product=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
  - Back-to-back a=3,b=5 then a=7,b=0 -> 15 then 0 on consecutive cycles.
- Signed corners:
  - -2^63 * -2^63 (both 0x8000_0000_0000_0000, signed) -> 0x4000_0000_0000_0000_0000_0000_0000_0000.
  - -1 * 5 signed -> 0xFFFF...FFFB (128-bit).
  - 0 * -7 signed -> 0.
  - Same -1 * 5 with in_signed=0 -> 0x4_FFFF_FFFF_FFFF_FFFB.
- Backpressure:
  - Issue 4 ops with out_ready=0 -> in_flight reaches 3, in_ready=0, out_product holds the first result unchanged.
  - Raise out_ready -> results emerge in issue order, none lost or duplicated; 4th op accepted in the same cycle the first is consumed.
- Reset mid-operation:
  - 3 ops in flight with out_ready=0, assert reset -> out_valid=0, in_flight=0.
  - After release, a new op 2*3 -> out_product=6 after 3 cycles, with no stale results emitted.
- Random regression: 10k random signed/unsigned pairs with random out_ready/in_valid -> every product matches the reference model, in order, with latency >= 3.
